result_demux_32: RTL and testbench

- Registered 1-to-2 demultiplexer for adder results: the inverse of the select-based result multiplexer.
- Takes one {carry, sum} result stream plus a select bit and steers each accepted result into one of two independently buffered output channels.
- Uses valid/ready handshakes on every side, and each output holds one result.
- Sits between the adder datapath and two downstream consumers, e.g. the accumulate path and the writeback path.

---
 rtl/result_demux_32_pkg.sv | 20 ++
 rtl/result_demux_32_slot.sv | 49 ++++
 rtl/result_demux_32.sv | 59 +++++
 tb/tb_result_demux_32.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/result_demux_32_pkg.sv
// result_demux_32_pkg: shared widths, channel indices and result types for the adder result path.
package result_demux_32_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef struct packed {
        logic              carry;
        logic [DATA_W-1:0] sum;
    } result_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/result_demux_32_slot.sv
// result_slot: one-entry valid/ready holding register with a modulo delivery counter.
module result_slot
    import result_demux_32_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [WIDTH:0]       data_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [WIDTH:0]       data_o,
    output logic                 free_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    slot_state_e          state_q, state_d;
    logic [WIDTH:0]       data_q, data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 fire;

    assign valid_o = (state_q == SLOT_FULL);
    assign fire    = valid_o && ready_i;
    // A full slot can take a new result in the same cycle it is drained.
    assign free_o  = !valid_o || ready_i;
    assign data_o  = data_q;
    assign count_o = cnt_q;

    always_comb begin
        state_d = load_i ? SLOT_FULL : (fire ? SLOT_EMPTY : state_q);
        data_d  = load_i ? data_i : data_q;
        cnt_d   = fire ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/result_demux_32.sv
// result_demux_32: steers each accepted {carry, sum} result into one of two buffered channels.
module result_demux_32
    import result_demux_32_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_select,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_carry,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out0_sum,
    output logic                 out0_carry,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [WIDTH-1:0]     out1_sum,
    output logic                 out1_carry,
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1
);

    logic free0, free1, accept, load0, load1;

    // Readiness depends only on the selected channel, so a stalled channel never blocks the other.
    assign in_ready = (in_select == CH1) ? free1 : free0;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (in_select == CH0);
    assign load1    = accept && (in_select == CH1);

    result_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load0),
        .data_i  ({in_carry, in_sum}),
        .ready_i (out0_ready),
        .valid_o (out0_valid),
        .data_o  ({out0_carry, out0_sum}),
        .free_o  (free0),
        .count_o (count0)
    );

    result_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load1),
        .data_i  ({in_carry, in_sum}),
        .ready_i (out1_ready),
        .valid_o (out1_valid),
        .data_o  ({out1_carry, out1_sum}),
        .free_o  (free1),
        .count_o (count1)
    );

endmodule

// File: tb/tb_result_demux_32.sv
// tb_result_demux_32: directed stimulus with per-channel expected-result queues checked by a monitor.
module tb_result_demux_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_select = 1'b0;
    logic [31:0] in_sum = '0;
    logic        in_carry = 1'b0;
    logic        out0_valid, out1_valid;
    logic        out0_ready = 1'b0;
    logic        out1_ready = 1'b0;
    logic [31:0] out0_sum, out1_sum;
    logic        out0_carry, out1_carry;
    logic [15:0] count0, count1;

    int n_total = 0;
    int n_pass  = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    result_demux_32 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select),
        .in_sum(in_sum), .in_carry(in_carry),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out0_sum(out0_sum), .out0_carry(out0_carry),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out1_sum(out1_sum), .out1_carry(out1_carry),
        .count0(count0), .count1(count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic sel, input logic [31:0] s, input logic c);
        in_valid  = 1'b1;
        in_select = sel;
        in_sum    = s;
        in_carry  = c;
        #1;
    endtask

    // Handshakes complete at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst_n && out0_valid && out0_ready) begin
            if (q0.size() == 0) chk("ch0_unexpected", 64'd1, 64'd0);
            else chk("ch0_data", {31'd0, out0_carry, out0_sum}, {31'd0, q0.pop_front()});
        end
        if (rst_n && out1_valid && out1_ready) begin
            if (q1.size() == 0) chk("ch1_unexpected", 64'd1, 64'd0);
            else chk("ch1_data", {31'd0, out1_carry, out1_sum}, {31'd0, q1.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_count0", count0, 0);
        chk("rst_sum0", out0_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        // first accept on channel 0
        offer(1'b0, 32'h0000_0001, 1'b1);
        chk("a_in_ready", in_ready, 1);
        q0.push_back({1'b1, 32'h0000_0001});
        cyc();
        in_valid = 1'b0;
        chk("a_out0_valid", out0_valid, 1);
        chk("a_out0_sum", out0_sum, 32'h1);
        chk("a_out0_carry", out0_carry, 1);
        chk("a_out1_valid", out1_valid, 0);
        chk("a_count0", count0, 0);
        // channel 0 stalled, channel 1 still accepts
        offer(1'b0, 32'hAAAA_AAAA, 1'b0);
        chk("b_in_ready_sel0", in_ready, 0);
        cyc();
        chk("b_out0_hold", out0_sum, 32'h1);
        offer(1'b1, 32'h5555_5555, 1'b0);
        chk("b_in_ready_sel1", in_ready, 1);
        q1.push_back({1'b0, 32'h5555_5555});
        cyc();
        in_valid = 1'b0;
        chk("b_out1_valid", out1_valid, 1);
        chk("b_out1_sum", out1_sum, 32'h5555_5555);
        chk("b_out0_sum", out0_sum, 32'h1);
        chk("b_out0_valid", out0_valid, 1);
        // streaming on channel 1 behind the held 0x5555_5555
        out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'(i), 1'(i & 1));
            chk("c_in_ready", in_ready, 1);
            q1.push_back({1'(i & 1), 32'(i)});
            cyc();
            chk("c_out1_sum", out1_sum, 64'(i));
        end
        in_valid = 1'b0;
        cyc();
        out1_ready = 1'b0;
        chk("c_out1_empty", out1_valid, 0);
        chk("c_count1", count1, 9);
        // drain 0x1, load 0x10, then drain 0x10 and refill 0x20 together
        out0_ready = 1'b1;
        cyc();
        out0_ready = 1'b0;
        chk("d_count0_1", count0, 1);
        offer(1'b0, 32'h10, 1'b0);
        q0.push_back({1'b0, 32'h10});
        cyc();
        out0_ready = 1'b1;
        offer(1'b0, 32'h20, 1'b1);
        chk("d_in_ready", in_ready, 1);
        q0.push_back({1'b1, 32'h20});
        cyc();
        chk("d_out0_valid", out0_valid, 1);
        chk("d_out0_sum", out0_sum, 32'h20);
        chk("d_count0_2", count0, 2);
        // stream until 65536 total channel-0 deliveries
        for (int k = 0; k < 65533; k++) begin
            offer(1'b0, 32'hDEAD_0000 ^ 32'(k), 1'(k & 1));
            q0.push_back({1'(k & 1), 32'hDEAD_0000 ^ 32'(k)});
            cyc();
        end
        in_valid = 1'b0;
        chk("e_count0_max", count0, 16'hFFFF);
        cyc();
        out0_ready = 1'b0;
        chk("e_count0_wrap", count0, 0);
        chk("e_count1_keep", count1, 9);
        chk("e_q0_empty", q0.size(), 0);
        chk("e_q1_empty", q1.size(), 0);
        // fill both channels, then reset between edges
        offer(1'b0, 32'h77, 1'b1);
        cyc();
        offer(1'b1, 32'h88, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("f_both_full", {out0_valid, out1_valid}, 2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("f_out0_valid", out0_valid, 0);
        chk("f_out1_valid", out1_valid, 0);
        chk("f_count0", count0, 0);
        chk("f_count1", count1, 0);
        chk("f_out1_sum", {out1_carry, out1_sum}, 0);
        #2;
        rst_n = 1'b1;
        cyc();
        in_select = 1'b0;
        #1;
        chk("f_in_ready_sel0", in_ready, 1);
        in_select = 1'b1;
        #1;
        chk("f_in_ready_sel1", in_ready, 1);
        chk("f_still_empty", {out0_valid, out1_valid}, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
